// File: rtl/sccb_config_sequencer_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer:
// FSM states, frame/phase positions, delay marker and register addresses.
package sccb_config_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_START_C,
        ST_BITS,
        ST_STOP_C,
        ST_GAP,
        ST_FIN,
        ST_ERR
    } state_t;

    localparam int FRAME_BITS = 27;
    localparam int PHASE_BITS = 9;

    localparam logic [1:0] QTR_0 = 2'd0;
    localparam logic [1:0] QTR_1 = 2'd1;
    localparam logic [1:0] QTR_2 = 2'd2;
    localparam logic [1:0] QTR_3 = 2'd3;

    localparam logic [7:0] DELAY_MARKER = 8'hFF;

    localparam logic [7:0] REG_COM7   = 8'h12;
    localparam logic [7:0] REG_COM15  = 8'h40;
    localparam logic [7:0] REG_RGB444 = 8'h8C;
    localparam logic [7:0] REG_CLKRC  = 8'h11;

    // The 9th bit of each 9-bit phase is the slave's don't-care/ACK slot.
    function automatic logic is_ack_bit(input logic [4:0] bit_idx);
        return (bit_idx == 5'(PHASE_BITS - 1)) ||
               (bit_idx == 5'(2 * PHASE_BITS - 1)) ||
               (bit_idx == 5'(3 * PHASE_BITS - 1));
    endfunction

endpackage

// File: rtl/sccb_config_sequencer_rom.sv
// OV7670 register ROM: index -> {addr, data}; addr 8'hFF marks a settle delay.
// Soft reset first, then RGB444 output at QCIF resolution.
module ov7670_reg_rom
    import sccb_config_sequencer_pkg::*;
(
    input  logic [7:0] index_i,
    output logic [7:0] addr_o,
    output logic [7:0] data_o
);

    always_comb begin
        addr_o = DELAY_MARKER;
        data_o = 8'h00;
        case (index_i)
            8'd0:  begin addr_o = REG_COM7;   data_o = 8'h80; end
            8'd1:  begin addr_o = DELAY_MARKER; data_o = 8'h00; end
            8'd2:  begin addr_o = REG_RGB444; data_o = 8'h02; end
            8'd3:  begin addr_o = REG_COM7;   data_o = 8'h0C; end
            8'd4:  begin addr_o = REG_COM15;  data_o = 8'hD0; end
            8'd5:  begin addr_o = REG_CLKRC;  data_o = 8'h01; end
            8'd6:  begin addr_o = 8'h3A;      data_o = 8'h04; end
            8'd7:  begin addr_o = 8'h0C;      data_o = 8'h0C; end
            8'd8:  begin addr_o = 8'h3E;      data_o = 8'h11; end
            8'd9:  begin addr_o = 8'h72;      data_o = 8'h11; end
            8'd10: begin addr_o = 8'h73;      data_o = 8'hF1; end
            8'd11: begin addr_o = 8'h70;      data_o = 8'h3A; end
            8'd12: begin addr_o = 8'h71;      data_o = 8'h35; end
            8'd13: begin addr_o = 8'hA2;      data_o = 8'h02; end
            8'd14: begin addr_o = 8'h13;      data_o = 8'hE7; end
            default: begin addr_o = DELAY_MARKER; data_o = 8'h00; end
        endcase
    end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the OV7670 register ROM and issues one 3-phase SCCB write per entry.
// Define SCCB_ACK_CHECK_EN to abort into ERROR when a 9th-bit sample reads 1.
module sccb_config_sequencer
    import sccb_config_sequencer_pkg::*;
#(
    parameter int         QTR_DIV      = 63,
    parameter int         NUM_REGS     = 16,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         DELAY_CYCLES = 25000,
    parameter int         GAP_QTRS     = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       SIOD_IN,
    output logic       SIOC,
    output logic       SIOD_OUT,
    output logic       SIOD_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [7:0] REG_INDEX
);

    localparam int DIV_W = $clog2(QTR_DIV + 1);
    localparam int CNT_W = $clog2(DELAY_CYCLES + GAP_QTRS + 1);

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [1:0]              qtr_q, qtr_d;
    logic [4:0]              bit_q, bit_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [8:0]              idx_q, idx_d;
    logic [FRAME_BITS-1:0]   sh_q, sh_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tick;
    logic [7:0]              rom_addr, rom_data;

`ifdef SCCB_ACK_CHECK_EN
    logic                    err_q, err_d;
    logic                    nack_q, nack_d;
`else
    logic                    siod_in_unused;
    assign siod_in_unused = SIOD_IN;
`endif

    ov7670_reg_rom u_rom (
        .index_i (idx_q[7:0]),
        .addr_o  (rom_addr),
        .data_o  (rom_data)
    );

    assign tick = (div_q == DIV_W'(QTR_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef SCCB_ACK_CHECK_EN
        err_d   = err_q;
        nack_d  = nack_q;
`endif
        if (state_q inside {ST_START_C, ST_BITS, ST_STOP_C, ST_GAP})
            div_d = tick ? '0 : div_q + DIV_W'(1);

        case (state_q)
            ST_IDLE, ST_FIN, ST_ERR: begin
                if (state_q == ST_FIN)
                    state_d = ST_IDLE;
                if (START) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    idx_d   = '0;
`ifdef SCCB_ACK_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                qtr_d = QTR_0;
                bit_d = '0;
                cnt_d = '0;
`ifdef SCCB_ACK_CHECK_EN
                nack_d = 1'b0;
`endif
                if (idx_q == 9'(NUM_REGS)) begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (rom_addr == DELAY_MARKER) begin
                    state_d = ST_WAIT;
                end else begin
                    sh_d    = {DEV_ADDR, 1'b1, rom_addr, 1'b1, rom_data, 1'b1};
                    state_d = ST_START_C;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(DELAY_CYCLES - 1)) begin
                    idx_d   = idx_q + 9'd1;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_START_C: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == QTR_2) begin
                        qtr_d   = QTR_0;
                        state_d = ST_BITS;
                    end
                end
            end
            ST_BITS: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == QTR_3) begin
`ifdef SCCB_ACK_CHECK_EN
                        if (is_ack_bit(bit_q) && SIOD_IN)
                            nack_d = 1'b1;
`endif
                        sh_d  = {sh_q[FRAME_BITS-2:0], 1'b0};
                        bit_d = bit_q + 5'd1;
                        if (bit_q == 5'(FRAME_BITS - 1)) begin
                            bit_d   = '0;
                            state_d = ST_STOP_C;
                        end
                    end
                end
            end
            ST_STOP_C: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == QTR_2) begin
                        qtr_d   = QTR_0;
                        cnt_d   = '0;
                        idx_d   = idx_q + 9'd1;
                        state_d = ST_GAP;
`ifdef SCCB_ACK_CHECK_EN
                        // A failed write leaves REG_INDEX on the offending entry.
                        if (nack_q) begin
                            idx_d   = idx_q;
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end
`endif
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(GAP_QTRS - 1))
                        state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            qtr_q   <= QTR_0;
            bit_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            err_q   <= 1'b0;
            nack_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SCCB_ACK_CHECK_EN
            err_q   <= err_d;
            nack_q  <= nack_d;
`endif
        end
    end

    // Frame shifter is only read in BITS after LOAD fills it, so it needs no reset.
    always_ff @(posedge CLK) begin
        sh_q <= sh_d;
    end

    always_comb begin
        SIOC     = 1'b1;
        SIOD_OUT = 1'b1;
        SIOD_OE  = 1'b1;
        case (state_q)
            ST_START_C: begin
                SIOC     = (qtr_q != QTR_2);
                SIOD_OUT = (qtr_q == QTR_0);
            end
            ST_BITS: begin
                SIOC     = qtr_q[1];
                SIOD_OUT = sh_q[FRAME_BITS-1];
                SIOD_OE  = !is_ack_bit(bit_q);
            end
            ST_STOP_C: begin
                SIOC     = (qtr_q != QTR_0);
                SIOD_OUT = (qtr_q == QTR_2);
            end
            default: ;
        endcase
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign REG_INDEX = idx_q[7:0];
`ifdef SCCB_ACK_CHECK_EN
    assign ERROR     = err_q;
`else
    assign ERROR     = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: decodes the SCCB bus and checks writes,
// spacing, sequence latency, reset abort, ignored START and ACK handling.
module tb_sccb_config_sequencer;

    localparam int Q      = 4;
    localparam int NR     = 3;
    localparam int D      = 100;
    localparam int G      = 4;
    localparam int BUDGET = 5000;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       SIOD_IN = 1'b0;
    logic       SIOC, SIOD_OUT, SIOD_OE, BUSY, DONE, ERROR;
    logic [7:0] REG_INDEX;

    sccb_config_sequencer #(
        .QTR_DIV      (Q),
        .NUM_REGS     (NR),
        .DEV_ADDR     (8'h42),
        .DELAY_CYCLES (D),
        .GAP_QTRS     (G)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SIOD_IN   (SIOD_IN),
        .SIOC      (SIOC),
        .SIOD_OUT  (SIOD_OUT),
        .SIOD_OE   (SIOD_OE),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERROR     (ERROR),
        .REG_INDEX (REG_INDEX)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ROM contents as the expected sequence of writes,
    // idle distance between consecutive writes and total START->DONE latency.
    logic [7:0] m_addr [NR] = '{8'h12, 8'hFF, 8'h8C};
    logic [7:0] m_data [NR] = '{8'h80, 8'h00, 8'h02};
    int exp_txn[$];
    int exp_gap[$];
    int exp_lat;

    initial begin
        int nd;
        nd = 0;
        exp_lat = 2;
        for (int e = 0; e < NR; e++) begin
            if (m_addr[e] == 8'hFF) begin
                nd++;
                exp_lat += 1 + D;
            end else begin
                // stop q2 + gap + LOAD + (WAIT+LOAD per delay) + start q0
                exp_gap.push_back(Q + G * Q + 1 + nd * (D + 1) + Q);
                exp_txn.push_back({8'h42, m_addr[e], m_data[e]});
                // LOAD + start(3q) + 27 bits(4q each) + stop(3q) + gap
                exp_lat += 1 + (3 + 27 * 4 + 3 + G) * Q;
                nd = 0;
            end
        end
    end

    // Bus monitor
    int          cyc = 0;
    int          mon_skip = 3;
    int          txn_done_cnt = 0;
    int          last_stop = 0;
    int          nbits = 0;
    bit          in_txn = 0;
    logic [26:0] bits;
    logic        psc = 1'b1, psd = 1'b1;
    bit          nack_en = 0;

    initial begin
        logic sc, sd;
        forever begin
            @(negedge CLK);
            cyc++;
            sc = SIOC;
            sd = SIOD_OE ? SIOD_OUT : 1'b1;
            if (mon_skip > 0) begin
                mon_skip--;
                in_txn = 0;
            end else if (psc && sc && psd && !sd) begin
                check("start_outside_txn", 32'(in_txn), 0);
                if (txn_done_cnt > 0 && txn_done_cnt < exp_gap.size())
                    check("gap_cycles", cyc - last_stop, exp_gap[txn_done_cnt]);
                in_txn = 1;
                nbits  = 0;
                bits   = '0;
            end else if (psc && sc && !psd && sd) begin
                check("stop_inside_txn", 32'(in_txn), 1);
                if (in_txn) begin
                    check("frame_edges", nbits, 28);
                    if (txn_done_cnt < exp_txn.size())
                        check("write_bytes", {8'h00, bits[26:19], bits[17:10], bits[8:1]},
                              exp_txn[txn_done_cnt]);
                    else
                        check("extra_write", txn_done_cnt, exp_txn.size());
                    txn_done_cnt++;
                    last_stop = cyc;
                end
                in_txn = 0;
            end else if (!psc && sc && in_txn) begin
                if (nbits < 27) begin
                    bits = {bits[25:0], sd};
                    if (nbits == 8 || nbits == 17 || nbits == 26)
                        check("ack_bit_released", 32'(SIOD_OE), 0);
                end
                nbits++;
            end
            psc = sc;
            psd = sd;
        end
    end

    // Slave: random data while the master drives, ACK (or forced NACK) on 9th bits.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            SIOD_IN = SIOD_OE ? 1'($urandom_range(0, 1)) : (nack_en && txn_done_cnt >= 1);
        end
    end

    task automatic run_sequence(input bit spurious, input bit expect_err);
        int n;
        bit fin;
        repeat ($urandom_range(0, 15)) @(posedge CLK);
        @(posedge CLK);
        #1 START = 1'b1;
        txn_done_cnt = 0;
        n   = 0;
        fin = 0;
        while (!fin && n < BUDGET) begin
            @(posedge CLK);
            #1;
            n++;
            if (n == 1) begin
                check("busy_after_start", 32'(BUSY), 1);
                check("done_cleared", 32'(DONE), 0);
            end
            fin   = DONE || ERROR;
            START = spurious && BUSY && ($urandom_range(0, 40) == 0);
        end
        START = 1'b0;
        check("sequence_finished", 32'(fin), 1);
        repeat (3) @(posedge CLK);
        #1;
        check("busy_end", 32'(BUSY), 0);
        if (expect_err) begin
            check("err_error", 32'(ERROR), 1);
            check("err_done", 32'(DONE), 0);
            check("err_index", 32'(REG_INDEX), 2);
            check("err_writes", txn_done_cnt, 2);
        end else begin
            check("latency", n, exp_lat);
            check("done_sticky", 32'(DONE), 1);
            check("error_low", 32'(ERROR), 0);
            check("final_index", 32'(REG_INDEX), NR);
            check("write_count", txn_done_cnt, exp_txn.size());
        end
    endtask

    initial begin
        int  target;
        int  n;
        repeat (4) @(posedge CLK);
        #1 RESET = 1'b0;
        check("rst_sioc", 32'(SIOC), 1);
        check("rst_siod", 32'(SIOD_OUT), 1);
        check("rst_oe", 32'(SIOD_OE), 1);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_error", 32'(ERROR), 0);
        check("rst_index", 32'(REG_INDEX), 0);

        // Full sequence with STARTs pulsed while busy
        run_sequence(1, 0);

        // Reset in the middle of entry 0's bit phase, then a clean rerun
        @(posedge CLK);
        #1 START = 1'b1;
        txn_done_cnt = 0;
        @(posedge CLK);
        #1 START = 1'b0;
        target = $urandom_range(2, 20);
        n = 0;
        while (!(in_txn && nbits >= target) && n < BUDGET) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("reset_point_reached", 32'(in_txn && nbits >= target), 1);
        RESET    = 1'b1;
        mon_skip = 2;
        @(posedge CLK);
        #1 RESET = 1'b0;
        check("midrst_sioc", 32'(SIOC), 1);
        check("midrst_siod", 32'(SIOD_OUT), 1);
        check("midrst_busy", 32'(BUSY), 0);
        check("midrst_index", 32'(REG_INDEX), 0);
        run_sequence(0, 0);

        // Slave refuses entry 2
        nack_en = 1;
`ifdef SCCB_ACK_CHECK_EN
        run_sequence(0, 1);
`else
        run_sequence(0, 0);
`endif
        nack_en = 0;

        // A new START leaves DONE or ERR and runs the whole ROM again
        run_sequence(1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
